// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: FSM encoding, ALU opcodes,
// flag bit positions and the registered operation record.
package alu_arbiter_pkg;

    localparam int XLEN = 32;
    localparam int SHW  = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // rsp_flags = {OverFlow, Carry, Zero, Negative}
    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef struct packed {
        logic [3:0]      ctrl;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } op_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU shared by both requesters. Carry on SUB is the
// carry-out of a + ~b + 1, i.e. set when no borrow occurs (a >= b unsigned).
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      ctrl,
    output logic [XLEN-1:0] result,
    output logic [3:0]      flags
);

    logic            sub;
    logic [XLEN-1:0] bx;
    logic [XLEN:0]   sum;
    logic            cy;
    logic            ov;

    assign sub = (ctrl == ALU_SUB);
    assign bx  = sub ? ~b : b;
    assign sum = {1'b0, a} + {1'b0, bx} + {{XLEN{1'b0}}, sub};

    always_comb begin
        result = '0;
        cy     = 1'b0;
        ov     = 1'b0;
        case (ctrl)
            ALU_ADD, ALU_SUB: begin
                result = sum[XLEN-1:0];
                cy     = sum[XLEN];
                // same-sign inputs (after inversion) producing a different sign
                ov     = (a[XLEN-1] == bx[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
            end
            ALU_XOR:  result = a ^ b;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_SLL:  result = a << b[SHW-1:0];
            ALU_SRL:  result = a >> b[SHW-1:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[SHW-1:0]);
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            default:  result = '0;
        endcase
        flags         = '0;
        flags[FLAG_V] = ov;
        flags[FLAG_C] = cy;
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_N] = result[XLEN-1];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port front end to a single shared ALU: arbitrate, execute one cycle,
// then hold the response for the winning port until it is taken.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid0,
    input  logic            req_valid1,
    output logic            req_ready0,
    output logic            req_ready1,
    input  logic [XLEN-1:0] req_a0,
    input  logic [XLEN-1:0] req_a1,
    input  logic [XLEN-1:0] req_b0,
    input  logic [XLEN-1:0] req_b1,
    input  logic [3:0]      req_ctrl0,
    input  logic [3:0]      req_ctrl1,
    output logic            rsp_valid0,
    output logic            rsp_valid1,
    input  logic            rsp_ready0,
    input  logic            rsp_ready1,
    output logic [XLEN-1:0] rsp_result,
    output logic [3:0]      rsp_flags,
    output logic            busy
);

    state_t          state, state_nxt;
    logic [1:0]      vld;
    logic            gnt_id;
    logic            win;
    logic            last_gnt;
    logic            accept;
    logic            rsp_hs;
    op_t             op, req_op;
    logic [XLEN-1:0] alu_res;
    logic [3:0]      alu_flg;

    assign vld = {req_valid1, req_valid0};

    // On a tie round-robin favours the port not served last; otherwise port 0.
    always_comb begin
        if (RR_EN != 0 && (&vld))
            gnt_id = ~last_gnt;
        else
            gnt_id = ~vld[0];
    end

    assign req_op = gnt_id ? op_t'{req_ctrl1, req_a1, req_b1}
                           : op_t'{req_ctrl0, req_a0, req_b0};

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        rsp_hs    = 1'b0;
        case (state)
            IDLE: begin
                if (|vld) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (win ? rsp_ready1 : rsp_ready0) begin
                    rsp_hs    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req_ready0 = accept && !gnt_id;
    assign req_ready1 = accept &&  gnt_id;
    assign rsp_valid0 = (state == RESP) && !win;
    assign rsp_valid1 = (state == RESP) &&  win;
    assign busy       = (state != IDLE);

    alu_arbiter_alu u_alu (
        .a      (op.a),
        .b      (op.b),
        .ctrl   (op.ctrl),
        .result (alu_res),
        .flags  (alu_flg)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_gnt   <= 1'b1;
            win        <= 1'b0;
            op         <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op  <= req_op;
                win <= gnt_id;
            end
            if (state == EXEC) begin
                rsp_result <= alu_res;
                rsp_flags  <= alu_flg;
            end
            if (rsp_hs)
                last_gnt <= win;
        end
    end

endmodule
